// File: rtl/address_decoder_waitstate_if.sv
// Bus-side interface of the address decoder.
// Groups the 68k cycle signals (Address, AS_L, ExtReady_H), the decode-table
// programming port (CfgWrite_H, CfgIndex, CfgBase, CfgMask, CfgWaitStates,
// CfgEnable_H) and the decoder results (RegionSelect_H, HitIndex, Dtack_L,
// Berr_L, Busy_H).
//   master : CPU / configuration side (drives address, strobe, config)
//   slave  : decoder side (drives selects and acknowledges)
interface address_decoder_waitstate_if #(
    parameter int NUM_REGIONS = 8,
    parameter int ADDR_WIDTH  = 32,
    parameter int WS_WIDTH    = 4,
    parameter int IDX_WIDTH   = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
);
    logic [ADDR_WIDTH-1:0]  Address;
    logic                   AS_L;
    logic                   ExtReady_H;
    logic                   CfgWrite_H;
    logic [IDX_WIDTH-1:0]   CfgIndex;
    logic [ADDR_WIDTH-1:0]  CfgBase;
    logic [ADDR_WIDTH-1:0]  CfgMask;
    logic [WS_WIDTH-1:0]    CfgWaitStates;
    logic                   CfgEnable_H;
    logic [NUM_REGIONS-1:0] RegionSelect_H;
    logic [IDX_WIDTH-1:0]   HitIndex;
    logic                   Dtack_L;
    logic                   Berr_L;
    logic                   Busy_H;

    modport master (
        output Address, AS_L, ExtReady_H,
        output CfgWrite_H, CfgIndex, CfgBase, CfgMask, CfgWaitStates, CfgEnable_H,
        input  RegionSelect_H, HitIndex, Dtack_L, Berr_L, Busy_H
    );

    modport slave (
        input  Address, AS_L, ExtReady_H,
        input  CfgWrite_H, CfgIndex, CfgBase, CfgMask, CfgWaitStates, CfgEnable_H,
        output RegionSelect_H, HitIndex, Dtack_L, Berr_L, Busy_H
    );
endinterface

// File: rtl/address_decoder_waitstate.sv
// Registered, programmable 68k address decoder with wait-state generation.
// A table of NUM_REGIONS windows (base/mask/wait-states/enable) is matched
// against the address at the first edge where AS_L is low; the lowest-index
// hit drives a one-hot chip select. DTACK follows after the region's wait
// states (or an external ready when the wait field is all ones); misses and
// stalled external cycles get BERR after TIMEOUT_CYCLES.
// Ports:
//   Clk      : system clock, rising edge
//   Reset_H  : synchronous active-high reset (FSM, outputs and table)
//   bus      : slave modport carrying the cycle, config and result signals
module address_decoder_waitstate #(
    parameter int                  NUM_REGIONS    = 8,
    parameter int                  ADDR_WIDTH     = 32,
    parameter int                  WS_WIDTH       = 4,
    parameter int                  TIMEOUT_CYCLES = 255,
    parameter logic [ADDR_WIDTH-1:0] BOOT_MASK    = 32'hFFFF_8000
) (
    input logic                       Clk,
    input logic                       Reset_H,
    address_decoder_waitstate_if.slave bus
);
    localparam int IDX_WIDTH = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    // Counter must cover both the longest wait-state count and the timeout.
    localparam int CNT_WIDTH = ($clog2(TIMEOUT_CYCLES) > WS_WIDTH) ? $clog2(TIMEOUT_CYCLES) : WS_WIDTH;

    localparam logic [WS_WIDTH-1:0]    WS_EXT   = {WS_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]   CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]   CNT_ONE  = CNT_WIDTH'(1'b1);
    localparam logic [CNT_WIDTH-1:0]   CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_WIDTH:0]     NUM_REGIONS_EXT = (IDX_WIDTH + 1)'(NUM_REGIONS);
    localparam logic [NUM_REGIONS-1:0] SEL_LSB  = NUM_REGIONS'(1'b1);
    localparam logic [NUM_REGIONS-1:0] SEL_NONE = {NUM_REGIONS{1'b0}};
    localparam logic [IDX_WIDTH-1:0]   IDX_ZERO = {IDX_WIDTH{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_EXTWAIT = 3'd2,
        ST_ACK     = 3'd3,
        ST_TIMEOUT = 3'd4,
        ST_BERR    = 3'd5,
        ST_END     = 3'd6
    } state_t;

    logic [ADDR_WIDTH-1:0]  base_r [NUM_REGIONS];
    logic [ADDR_WIDTH-1:0]  mask_r [NUM_REGIONS];
    logic [WS_WIDTH-1:0]    ws_r   [NUM_REGIONS];
    logic [NUM_REGIONS-1:0] en_r;

    logic [NUM_REGIONS-1:0] hit_vec_s;
    logic                   hit_any_s;
    logic [IDX_WIDTH-1:0]   hit_idx_s;
    logic [WS_WIDTH-1:0]    hit_ws_s;

    state_t                 state_r;
    logic [CNT_WIDTH-1:0]   cnt_r;
    logic [NUM_REGIONS-1:0] sel_r;
    logic [IDX_WIDTH-1:0]   idx_r;
    logic                   dtack_r;
    logic                   berr_r;
    logic                   busy_r;

    // Decode table: boot ROM window in entry 0 after reset, run-time writes otherwise.
    always_ff @(posedge Clk) begin
        if (Reset_H) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                base_r[i] <= {ADDR_WIDTH{1'b0}};
                mask_r[i] <= {ADDR_WIDTH{1'b0}};
                ws_r[i]   <= {WS_WIDTH{1'b0}};
                en_r[i]   <= 1'b0;
            end
            mask_r[0] <= BOOT_MASK;
            en_r[0]   <= 1'b1;
        end else if (bus.CfgWrite_H && ({1'b0, bus.CfgIndex} < NUM_REGIONS_EXT)) begin
            base_r[bus.CfgIndex] <= bus.CfgBase;
            mask_r[bus.CfgIndex] <= bus.CfgMask;
            ws_r[bus.CfgIndex]   <= bus.CfgWaitStates;
            en_r[bus.CfgIndex]   <= bus.CfgEnable_H;
        end else begin
            en_r <= en_r;
        end
    end

    // Window match and priority resolution; scanning downwards lets index 0 win.
    always_comb begin
        hit_idx_s = IDX_ZERO;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            hit_vec_s[i] = en_r[i] && ((bus.Address & mask_r[i]) == (base_r[i] & mask_r[i]));
        end
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            hit_idx_s = hit_vec_s[i] ? IDX_WIDTH'(i) : hit_idx_s;
        end
        hit_any_s = |hit_vec_s;
        hit_ws_s  = ws_r[hit_idx_s];
    end

    // Bus-cycle FSM with registered select/acknowledge outputs.
    always_ff @(posedge Clk) begin
        if (Reset_H) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            sel_r   <= SEL_NONE;
            idx_r   <= IDX_ZERO;
            dtack_r <= 1'b1;
            berr_r  <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!bus.AS_L) begin
                        busy_r <= 1'b1;
                        if (hit_any_s) begin
                            sel_r <= SEL_LSB << hit_idx_s;
                            idx_r <= hit_idx_s;
                            if (hit_ws_s == WS_EXT) begin
                                state_r <= ST_EXTWAIT;
                                cnt_r   <= CNT_ZERO;
                            end else begin
                                state_r <= ST_WAIT;
                                cnt_r   <= CNT_WIDTH'(hit_ws_s);
                            end
                        end else begin
                            state_r <= ST_TIMEOUT;
                            cnt_r   <= CNT_ZERO;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (bus.AS_L) begin
                        state_r <= ST_END;
                        sel_r   <= SEL_NONE;
                        idx_r   <= IDX_ZERO;
                    end else if (cnt_r == CNT_ZERO) begin
                        state_r <= ST_ACK;
                        dtack_r <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_EXTWAIT: begin
                    // Ready takes precedence over a timeout reached on the same edge.
                    if (bus.AS_L) begin
                        state_r <= ST_END;
                        sel_r   <= SEL_NONE;
                        idx_r   <= IDX_ZERO;
                    end else if (bus.ExtReady_H) begin
                        state_r <= ST_ACK;
                        dtack_r <= 1'b0;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r <= ST_BERR;
                        berr_r  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_TIMEOUT: begin
                    if (bus.AS_L) begin
                        state_r <= ST_END;
                        sel_r   <= SEL_NONE;
                        idx_r   <= IDX_ZERO;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r <= ST_BERR;
                        berr_r  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_ACK, ST_BERR: begin
                    if (bus.AS_L) begin
                        state_r <= ST_END;
                        sel_r   <= SEL_NONE;
                        idx_r   <= IDX_ZERO;
                        dtack_r <= 1'b1;
                        berr_r  <= 1'b1;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_END: begin
                    // Turnaround cycle: a strobe seen here is not decoded.
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= CNT_ZERO;
                    sel_r   <= SEL_NONE;
                    idx_r   <= IDX_ZERO;
                    dtack_r <= 1'b1;
                    berr_r  <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.RegionSelect_H = sel_r;
    assign bus.HitIndex       = idx_r;
    assign bus.Dtack_L        = dtack_r;
    assign bus.Berr_L         = berr_r;
    assign bus.Busy_H         = busy_r;
endmodule

// File: tb/tb_address_decoder_waitstate.sv
// Self-checking bench for address_decoder_waitstate: directed scenarios plus
// randomized bus cycles checked against a timing-rule reference model.
module tb_address_decoder_waitstate;
    localparam int NR = 8;
    localparam int AW = 32;
    localparam int WW = 4;
    localparam int TO = 16;
    localparam int IW = 3;

    logic clk;
    logic rst;
    int   tests_run;
    int   fails;

    // reference decode table
    logic [31:0] m_base [NR];
    logic [31:0] m_mask [NR];
    logic [3:0]  m_ws   [NR];
    logic        m_en   [NR];

    address_decoder_waitstate_if #(.NUM_REGIONS(NR), .ADDR_WIDTH(AW), .WS_WIDTH(WW)) bus_if ();

    address_decoder_waitstate #(
        .NUM_REGIONS(NR), .ADDR_WIDTH(AW), .WS_WIDTH(WW),
        .TIMEOUT_CYCLES(TO), .BOOT_MASK(32'hFFFF_8000)
    ) dut (
        .Clk(clk),
        .Reset_H(rst),
        .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [13:0] outs();
        return {bus_if.RegionSelect_H, bus_if.HitIndex, bus_if.Dtack_L, bus_if.Berr_L, bus_if.Busy_H};
    endfunction

    function automatic logic [13:0] pack(logic [7:0] s, logic [2:0] i, logic d, logic b, logic y);
        return {s, i, d, b, y};
    endfunction

    function automatic int model_winner(logic [31:0] a);
        for (int i = 0; i < NR; i++) begin
            if (m_en[i] && ((a & m_mask[i]) == (m_base[i] & m_mask[i]))) return i;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_base[i] = 32'h0; m_mask[i] = 32'h0; m_ws[i] = 4'h0; m_en[i] = 1'b0;
        end
        m_mask[0] = 32'hFFFF_8000;
        m_en[0]   = 1'b1;
    endtask

    task automatic write_cfg(int idx, logic [31:0] b, logic [31:0] m, logic [3:0] w, logic e);
        bus_if.CfgIndex = IW'(idx); bus_if.CfgBase = b; bus_if.CfgMask = m;
        bus_if.CfgWaitStates = w; bus_if.CfgEnable_H = e; bus_if.CfgWrite_H = 1'b1;
        tick();
        bus_if.CfgWrite_H = 1'b0;
        m_base[idx] = b; m_mask[idx] = m; m_ws[idx] = w; m_en[idx] = e;
    endtask

    task automatic release_bus();
        bus_if.AS_L = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_if.AS_L = 1'b0; bus_if.Address = 32'h0000_0010;
        bus_if.ExtReady_H = 1'b0; bus_if.CfgWrite_H = 1'b0;
        bus_if.CfgIndex = 3'd0; bus_if.CfgBase = 32'h0; bus_if.CfgMask = 32'h0;
        bus_if.CfgWaitStates = 4'h0; bus_if.CfgEnable_H = 1'b0;
        tick();
        tick();
        tests_run++; if (outs() !== pack(8'h00, 3'd0, 1'b1, 1'b1, 1'b0)) begin fails++; $display("FAIL reset_outputs: got %h want %h", outs(), pack(8'h00, 3'd0, 1'b1, 1'b1, 1'b0)); end
        bus_if.AS_L = 1'b1;
        rst = 1'b0;
        model_reset();
        tick();
    endtask

    task automatic test_boot();
        bus_if.Address = 32'h0000_1234; bus_if.AS_L = 1'b0;
        tick();
        tests_run++; if (outs() !== pack(8'h01, 3'd0, 1'b1, 1'b1, 1'b1)) begin fails++; $display("FAIL boot_e0: got %h want %h", outs(), pack(8'h01, 3'd0, 1'b1, 1'b1, 1'b1)); end
        tick();
        tests_run++; if (outs() !== pack(8'h01, 3'd0, 1'b0, 1'b1, 1'b1)) begin fails++; $display("FAIL boot_ack: got %h want %h", outs(), pack(8'h01, 3'd0, 1'b0, 1'b1, 1'b1)); end
        bus_if.Address = 32'h7000_0000;
        tick();
        tests_run++; if (outs() !== pack(8'h01, 3'd0, 1'b0, 1'b1, 1'b1)) begin fails++; $display("FAIL boot_hold: got %h want %h", outs(), pack(8'h01, 3'd0, 1'b0, 1'b1, 1'b1)); end
        bus_if.AS_L = 1'b1;
        tick();
        tests_run++; if (outs() !== pack(8'h00, 3'd0, 1'b1, 1'b1, 1'b1)) begin fails++; $display("FAIL boot_release: got %h want %h", outs(), pack(8'h00, 3'd0, 1'b1, 1'b1, 1'b1)); end
        tick();
        tests_run++; if (outs() !== pack(8'h00, 3'd0, 1'b1, 1'b1, 1'b0)) begin fails++; $display("FAIL boot_idle: got %h want %h", outs(), pack(8'h00, 3'd0, 1'b1, 1'b1, 1'b0)); end
    endtask

    task automatic test_wait_priority();
        write_cfg(2, 32'h0800_0000, 32'hFC00_0000, 4'd3, 1'b1);
        write_cfg(5, 32'h0800_0000, 32'hF000_0000, 4'd0, 1'b1);
        bus_if.Address = 32'h0900_0000; bus_if.AS_L = 1'b0;
        for (int k = 0; k <= 3; k++) begin
            tick();
            tests_run++; if (outs() !== pack(8'h04, 3'd2, 1'b1, 1'b1, 1'b1)) begin fails++; $display("FAIL ws3_wait k=%0d: got %h want %h", k, outs(), pack(8'h04, 3'd2, 1'b1, 1'b1, 1'b1)); end
        end
        tick();
        tests_run++; if (outs() !== pack(8'h04, 3'd2, 1'b0, 1'b1, 1'b1)) begin fails++; $display("FAIL ws3_ack: got %h want %h", outs(), pack(8'h04, 3'd2, 1'b0, 1'b1, 1'b1)); end
        release_bus();
        bus_if.Address = 32'h0C00_0000; bus_if.AS_L = 1'b0;
        tick();
        tick();
        tests_run++; if (outs() !== pack(8'h20, 3'd5, 1'b0, 1'b1, 1'b1)) begin fails++; $display("FAIL prio_region5: got %h want %h", outs(), pack(8'h20, 3'd5, 1'b0, 1'b1, 1'b1)); end
        release_bus();
    endtask

    task automatic test_miss();
        bus_if.Address = 32'h7000_0000; bus_if.AS_L = 1'b0;
        for (int k = 0; k < TO; k++) begin
            tick();
            tests_run++; if (outs() !== pack(8'h00, 3'd0, 1'b1, 1'b1, 1'b1)) begin fails++; $display("FAIL miss_wait k=%0d: got %h want %h", k, outs(), pack(8'h00, 3'd0, 1'b1, 1'b1, 1'b1)); end
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            tests_run++; if (outs() !== pack(8'h00, 3'd0, 1'b1, 1'b0, 1'b1)) begin fails++; $display("FAIL miss_berr k=%0d: got %h want %h", k, outs(), pack(8'h00, 3'd0, 1'b1, 1'b0, 1'b1)); end
        end
        bus_if.AS_L = 1'b1;
        tick();
        tests_run++; if (outs() !== pack(8'h00, 3'd0, 1'b1, 1'b1, 1'b1)) begin fails++; $display("FAIL miss_release: got %h want %h", outs(), pack(8'h00, 3'd0, 1'b1, 1'b1, 1'b1)); end
        tick();
    endtask

    task automatic test_ext_ready();
        write_cfg(3, 32'h0050_0000, 32'hFFFF_0000, 4'hF, 1'b1);
        bus_if.Address = 32'h0050_1234; bus_if.AS_L = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            tick();
            tests_run++; if (outs() !== pack(8'h08, 3'd3, 1'b1, 1'b1, 1'b1)) begin fails++; $display("FAIL ext_wait k=%0d: got %h want %h", k, outs(), pack(8'h08, 3'd3, 1'b1, 1'b1, 1'b1)); end
        end
        bus_if.ExtReady_H = 1'b1;
        tick();
        bus_if.ExtReady_H = 1'b0;
        tests_run++; if (outs() !== pack(8'h08, 3'd3, 1'b0, 1'b1, 1'b1)) begin fails++; $display("FAIL ext_ack: got %h want %h", outs(), pack(8'h08, 3'd3, 1'b0, 1'b1, 1'b1)); end
        release_bus();
        bus_if.AS_L = 1'b0;
        for (int k = 0; k < TO; k++) begin
            tick();
        end
        tests_run++; if (outs() !== pack(8'h08, 3'd3, 1'b1, 1'b1, 1'b1)) begin fails++; $display("FAIL ext_noready_before: got %h want %h", outs(), pack(8'h08, 3'd3, 1'b1, 1'b1, 1'b1)); end
        tick();
        tests_run++; if (outs() !== pack(8'h08, 3'd3, 1'b1, 1'b0, 1'b1)) begin fails++; $display("FAIL ext_noready_berr: got %h want %h", outs(), pack(8'h08, 3'd3, 1'b1, 1'b0, 1'b1)); end
        release_bus();
    endtask

    task automatic test_abort_reconfig();
        bus_if.Address = 32'h0900_0000; bus_if.AS_L = 1'b0;
        tick();
        tick();
        bus_if.AS_L = 1'b1;
        tick();
        tests_run++; if (outs() !== pack(8'h00, 3'd0, 1'b1, 1'b1, 1'b1)) begin fails++; $display("FAIL abort_clear: got %h want %h", outs(), pack(8'h00, 3'd0, 1'b1, 1'b1, 1'b1)); end
        for (int k = 0; k < 4; k++) begin
            tick();
            tests_run++; if (bus_if.Dtack_L !== 1'b1) begin fails++; $display("FAIL abort_no_dtack k=%0d: got %b want 1", k, bus_if.Dtack_L); end
        end
        bus_if.Address = 32'h0900_0000; bus_if.AS_L = 1'b0;
        tick();
        bus_if.Address = 32'h0000_0000;
        write_cfg(2, 32'h4000_0000, 32'hFC00_0000, 4'd0, 1'b1);
        tests_run++; if (outs() !== pack(8'h04, 3'd2, 1'b1, 1'b1, 1'b1)) begin fails++; $display("FAIL reconfig_e1: got %h want %h", outs(), pack(8'h04, 3'd2, 1'b1, 1'b1, 1'b1)); end
        tick();
        tick();
        tests_run++; if (outs() !== pack(8'h04, 3'd2, 1'b1, 1'b1, 1'b1)) begin fails++; $display("FAIL reconfig_e3: got %h want %h", outs(), pack(8'h04, 3'd2, 1'b1, 1'b1, 1'b1)); end
        tick();
        tests_run++; if (outs() !== pack(8'h04, 3'd2, 1'b0, 1'b1, 1'b1)) begin fails++; $display("FAIL reconfig_e4: got %h want %h", outs(), pack(8'h04, 3'd2, 1'b0, 1'b1, 1'b1)); end
        release_bus();
        bus_if.Address = 32'h0900_0000; bus_if.AS_L = 1'b0;
        tick();
        tick();
        tests_run++; if (outs() !== pack(8'h20, 3'd5, 1'b0, 1'b1, 1'b1)) begin fails++; $display("FAIL reconfig_next: got %h want %h", outs(), pack(8'h20, 3'd5, 1'b0, 1'b1, 1'b1)); end
        release_bus();
    endtask

    task automatic test_back_to_back();
        bus_if.Address = 32'h0000_0100; bus_if.AS_L = 1'b0;
        tick();
        tick();
        bus_if.AS_L = 1'b1;
        tick();
        bus_if.AS_L = 1'b0;
        tick();
        tests_run++; if (outs() !== pack(8'h00, 3'd0, 1'b1, 1'b1, 1'b0)) begin fails++; $display("FAIL b2b_end_ignored: got %h want %h", outs(), pack(8'h00, 3'd0, 1'b1, 1'b1, 1'b0)); end
        tick();
        tests_run++; if (outs() !== pack(8'h01, 3'd0, 1'b1, 1'b1, 1'b1)) begin fails++; $display("FAIL b2b_second_decode: got %h want %h", outs(), pack(8'h01, 3'd0, 1'b1, 1'b1, 1'b1)); end
        release_bus();
    endtask

    task automatic test_reset_midcycle();
        write_cfg(2, 32'h0800_0000, 32'hFC00_0000, 4'd3, 1'b1);
        bus_if.Address = 32'h0900_0000; bus_if.AS_L = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        tests_run++; if (outs() !== pack(8'h00, 3'd0, 1'b1, 1'b1, 1'b0)) begin fails++; $display("FAIL midreset_outputs: got %h want %h", outs(), pack(8'h00, 3'd0, 1'b1, 1'b1, 1'b0)); end
        rst = 1'b0;
        bus_if.AS_L = 1'b1;
        model_reset();
        tick();
        bus_if.AS_L = 1'b0;
        tick();
        tests_run++; if (outs() !== pack(8'h00, 3'd0, 1'b1, 1'b1, 1'b1)) begin fails++; $display("FAIL midreset_table_cleared: got %h want %h", outs(), pack(8'h00, 3'd0, 1'b1, 1'b1, 1'b1)); end
        release_bus();
    endtask

    task automatic test_random();
        logic [31:0] bases [5];
        logic [31:0] masks [5];
        bases[0] = 32'h0000_0000; bases[1] = 32'h0800_0000; bases[2] = 32'h0050_0000;
        bases[3] = 32'h8000_0000; bases[4] = 32'h1000_0000;
        masks[0] = 32'hFFFF_8000; masks[1] = 32'hFC00_0000; masks[2] = 32'hF000_0000;
        masks[3] = 32'hFFFF_0000; masks[4] = 32'hFFF0_0000;
        for (int t = 0; t < 30; t++) begin
            int w, term, hold, r;
            logic is_dtack;
            logic [31:0] a;
            logic [7:0] es;
            logic [2:0] ei;
            if (t % 3 == 0) begin
                write_cfg($urandom_range(0, NR - 1), bases[$urandom_range(0, 4)], masks[$urandom_range(0, 4)],
                          4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
            end
            if ($urandom_range(0, 4) == 0) a = $urandom;
            else a = bases[$urandom_range(0, 4)] | 32'($urandom_range(0, 32'h000F_FFFF));
            r = $urandom_range(1, TO + 2);
            hold = $urandom_range(0, 2);
            w = model_winner(a);
            if (w < 0) begin
                term = TO; is_dtack = 1'b0;
            end else if (m_ws[w] == 4'hF) begin
                term = (r <= TO) ? r : TO; is_dtack = (r <= TO);
            end else begin
                term = int'(m_ws[w]) + 1; is_dtack = 1'b1;
            end
            es = (w < 0) ? 8'h00 : (8'h01 << w);
            ei = (w < 0) ? 3'd0 : 3'(w);
            bus_if.Address = a; bus_if.AS_L = 1'b0; bus_if.ExtReady_H = 1'b0;
            for (int k = 0; k <= term + hold; k++) begin
                logic [13:0] exp_o;
                tick();
                exp_o = pack(es, ei, !(is_dtack && k >= term), !(!is_dtack && k >= term), 1'b1);
                tests_run++; if (outs() !== exp_o) begin fails++; $display("FAIL rand t=%0d k=%0d addr=%h: got %h want %h", t, k, a, outs(), exp_o); end
                bus_if.ExtReady_H = (w >= 0 && m_ws[w] == 4'hF && k + 1 == r);
            end
            bus_if.ExtReady_H = 1'b0;
            bus_if.AS_L = 1'b1;
            tick();
            tests_run++; if (outs() !== pack(8'h00, 3'd0, 1'b1, 1'b1, 1'b1)) begin fails++; $display("FAIL rand_release t=%0d: got %h want %h", t, outs(), pack(8'h00, 3'd0, 1'b1, 1'b1, 1'b1)); end
            tick();
            tests_run++; if (outs() !== pack(8'h00, 3'd0, 1'b1, 1'b1, 1'b0)) begin fails++; $display("FAIL rand_idle t=%0d: got %h want %h", t, outs(), pack(8'h00, 3'd0, 1'b1, 1'b1, 1'b0)); end
        end
    endtask

    initial begin
        tests_run = 0;
        fails = 0;
        rst = 1'b1;
        model_reset();
        test_reset();
        test_boot();
        test_wait_priority();
        test_miss();
        test_ext_ready();
        test_abort_reconfig();
        test_back_to_back();
        test_reset_midcycle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule

// File: doc/address_decoder_waitstate.md
Name: address_decoder_waitstate

Overview:
Parametrised, registered successor to the combinational board address decoder. It holds a run-time-programmable table of NUM_REGIONS address windows (base/mask/wait-states/enable) and decodes each 68k bus cycle into a one-hot, priority-resolved chip select. It generates DTACK after a per-region wait-state count or an external ready. Unmapped or stalled cycles receive BERR after a timeout. It sits between the CPU bus (Address, AS_L) and the memory/IO select and acknowledge logic.

Parameters:
NUM_REGIONS, 8, number of decode windows; index 0 has highest priority
ADDR_WIDTH, 32, address bus width
WS_WIDTH, 4, wait-state field width; the all-ones value means "wait for ExtReady_H"
TIMEOUT_CYCLES, 255, cycles before BERR on a miss or a stalled external cycle (>=1)
BOOT_MASK, 32'hFFFF_8000, reset mask of region 0 (32 KB boot ROM at address 0)

Ports:
Clk  in  1  system clock; all logic on the rising edge
Reset_H  in  1  synchronous, active-high reset
Address  in  ADDR_WIDTH  CPU address
AS_L  in  1  address strobe, active low
ExtReady_H  in  1  external acknowledge, used by regions whose WS is all-ones
CfgWrite_H  in  1  one-cycle table write strobe
CfgIndex  in  clog2(NUM_REGIONS)  table entry to write
CfgBase  in  ADDR_WIDTH  region base
CfgMask  in  ADDR_WIDTH  compare mask (1 = bit compared)
CfgWaitStates  in  WS_WIDTH  wait states
CfgEnable_H  in  1  region enable
RegionSelect_H  out  NUM_REGIONS  registered one-hot select
HitIndex  out  clog2(NUM_REGIONS)  index of the selected region; 0 when no region is selected
Dtack_L  out  1  data acknowledge, active low
Berr_L  out  1  bus error, active low
Busy_H  out  1  high whenever the state is not IDLE

Behaviour:
- Reset: state IDLE; RegionSelect_H=0, HitIndex=0, Dtack_L=1, Berr_L=1, Busy_H=0; counters cleared.
- Reset table: entry 0 = {Base 0, Mask BOOT_MASK, WS 0, enabled}; all other entries = {0, 0, 0, disabled}.
- Reset takes priority over every other input. Asserting reset mid-cycle aborts the cycle; outputs reach reset values at the next edge.
- Hit(i) = enable(i) && ((Address & Mask(i)) == (Base(i) & Mask(i))). The lowest hitting index wins, so the select is always one-hot or zero.
- Config write: entry CfgIndex is updated at the edge where CfgWrite_H=1. CfgIndex >= NUM_REGIONS is ignored. A write during an active cycle affects only later decodes; the latched index and WS of the current cycle are unchanged.
- FSM states: IDLE, WAIT, EXTWAIT, ACK, TIMEOUT, BERR, END.
- IDLE, edge E0 with AS_L=0:
  - Hit: latch index and WS; set RegionSelect_H and HitIndex. Go to WAIT with cnt=WS, or to EXTWAIT if WS is all-ones.
  - Miss: go to TIMEOUT with cnt=0.
- WAIT: if cnt==0, go to ACK and drive Dtack_L=0; otherwise decrement cnt. For WS=n, Dtack_L is first low after edge E0+n+1.
- EXTWAIT: ExtReady_H=1 goes to ACK. Otherwise count; after TIMEOUT_CYCLES cycles without ready, go to BERR.
- TIMEOUT: cnt increments each cycle. When cnt reaches TIMEOUT_CYCLES-1, go to BERR and drive Berr_L=0.
- ACK/BERR: Dtack_L or Berr_L is held low until AS_L is sampled high. At that edge, clear all selects and acknowledges and go to END. END goes to IDLE on the next edge, giving a minimum one-cycle turnaround; AS_L low in END is not decoded.
- Abort: AS_L sampled high in WAIT, EXTWAIT or TIMEOUT clears the outputs at that edge and goes to END. No acknowledge is issued.
- Address is sampled only at E0; later changes within the cycle are ignored.
- Dtack_L and Berr_L are never low together.

Test Plan:
- Boot ROM: after reset, AS_L=0 with Address=0x0000_1234 -> RegionSelect_H=0x01 at E0+1; Dtack_L=0 at E0+1; AS_L high -> all outputs inactive on the next edge.
- Wait states and priority: program entry 2 = {0x0800_0000, 0xFC00_0000, WS 3, en} and entry 5 = {0x0800_0000, 0xF000_0000, WS 0, en}. Address 0x0900_0000 -> select 0x04, HitIndex 2, Dtack_L low first at E0+4.
- Miss: Address 0x7000_0000 with TIMEOUT_CYCLES=16 -> no select; Berr_L=0 at E0+16 and held until AS_L high; Dtack_L stays 1.
- External ready: entry 3 = {0x0050_0000, 0xFFFF_0000, WS 0xF, en}; ExtReady_H pulsed at E0+5 -> Dtack_L=0 at E0+6. Repeat with no ready -> Berr_L after the timeout.
- Abort and mid-cycle reconfig: AS_L high at E0+2 during WS=3 -> no Dtack_L, select cleared. Rewriting entry 2 during a live cycle leaves the current Dtack timing unchanged.
- Reset mid-cycle: Reset_H=1 during WAIT -> reset output values at the next edge; the table returns to its boot contents.
